// File: rtl/token_fifo_pkg.sv
// -----------------------------------------------------------------------------
// token_fifo_pkg
// Shared constants and helpers for the token/readpointer dual-clock channel.
//   TOKEN_SYNC_STAGES : depth of each token synchronizer chain.
//   token_idx_width() : width of a slot index for a given number of slots.
//   token_slot_lsb()  : bit offset of slot i inside the flattened slot array.
// Configuration macro: TOKEN_RX_SYNC3_EN
//   defined   -> 3-stage synchronizers
//   undefined -> 2-stage synchronizers
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package token_fifo_pkg;

`ifdef TOKEN_RX_SYNC3_EN
    localparam int unsigned TOKEN_SYNC_STAGES = 3;
`else
    localparam int unsigned TOKEN_SYNC_STAGES = 2;
`endif

    // Default ring size; instances normally override it.
    localparam int unsigned TOKEN_DEFAULT_SLOTS = 8;

    // Index width is $clog2(slots); clamped to 1 so a degenerate ring
    // still yields a legal vector.
    function automatic int unsigned token_idx_width(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Slot i occupies [i*data_width +: data_width] of the flattened array.
    function automatic int unsigned token_slot_lsb(input int unsigned idx,
                                                   input int unsigned data_width);
        return idx * data_width;
    endfunction

endpackage

// File: rtl/token_sync.sv
// -----------------------------------------------------------------------------
// token_sync
// Array of independent multi-flop synchronizers, one chain per bit, all flops
// reset to 0. Used for the writer token bus on the reader side and for the
// reader pointer bus on the writer side.
// Ports:
//   clk_i   in  1      destination-domain clock
//   rstn_i  in  1      asynchronous active-low reset
//   async_i in  WIDTH  bus from the other clock domain
//   sync_o  out WIDTH  synchronized bus (STAGES cycles of delay)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module token_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Each bit gets its own chain: token bits toggle independently,
            // so no multi-bit coherency is needed or attempted.
            logic [STAGES-1:0] chain_q;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[STAGES-2:0], async_i[gi]};
                end
            end

            assign sync_o[gi] = chain_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/token_ring_fifo_reader.sv
// -----------------------------------------------------------------------------
// token_ring_fifo_reader
// Read-side endpoint of the token/readpointer dual-clock channel. Synchronizes
// the writer token bus, consumes full slots in ring order into a registered
// valid/ready output stage, and hands each slot back to the writer by toggling
// its readpointer bit at the same edge the word is captured.
// Ports:
//   clk_i         in  1                       reader clock
//   rstn_i        in  1                       asynchronous active-low reset
//   writetoken_i  in  BUFFER_WIDTH            writer tokens (async)
//   data_async_i  in  BUFFER_WIDTH*DATA_WIDTH writer slot array (quasi-static)
//   readpointer_o out BUFFER_WIDTH            slot release toggles to writer
//   data_o        out DATA_WIDTH              output payload (registered)
//   valid_o       out 1                       output valid (registered)
//   ready_i       in  1                       downstream ready
// Configuration macro: TOKEN_RX_SYNC3_EN (3 synchronizer stages when defined,
// 2 otherwise; token-to-valid latency is stages+1 cycles).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module token_ring_fifo_reader
    import token_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_WIDTH = TOKEN_DEFAULT_SLOTS
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [BUFFER_WIDTH-1:0]            writetoken_i,
    input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
    output logic [BUFFER_WIDTH-1:0]            readpointer_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
    input  logic                               ready_i
);

    localparam int unsigned IDX_W = token_idx_width(BUFFER_WIDTH);

    logic [BUFFER_WIDTH-1:0] wt_sync;
    logic [BUFFER_WIDTH-1:0] slot_full;
    logic [DATA_WIDTH-1:0]   slot_data [BUFFER_WIDTH];

    logic [IDX_W-1:0]        rd_idx_q,  rd_idx_d;
    logic [BUFFER_WIDTH-1:0] rdptr_q,   rdptr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic                    valid_q,   valid_d;

    logic                    out_free;
    logic                    load;

    token_sync #(
        .WIDTH  (BUFFER_WIDTH),
        .STAGES (TOKEN_SYNC_STAGES)
    ) u_wt_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .async_i (writetoken_i),
        .sync_o  (wt_sync)
    );

    // A slot is full while the writer's token and our pointer disagree.
    assign slot_full = wt_sync ^ rdptr_q;

    generate
        for (genvar gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_slot
            assign slot_data[gi] = data_async_i[token_slot_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
        end
    endgenerate

    // The output stage may take a new word when empty or being accepted now;
    // this keeps back-to-back transfers bubble-free.
    assign out_free = !valid_q || ready_i;
    assign load     = out_free && slot_full[rd_idx_q];

    always_comb begin
        rd_idx_d = rd_idx_q;
        rdptr_d  = rdptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        if (load) begin
            // Slot data is only read once its synchronized token says full,
            // so it has been stable for at least the synchronizer depth.
            data_d            = slot_data[rd_idx_q];
            valid_d           = 1'b1;
            // Release the slot immediately: the word now lives in data_q.
            rdptr_d[rd_idx_q] = ~rdptr_q[rd_idx_q];
            rd_idx_d          = (rd_idx_q == IDX_W'(BUFFER_WIDTH - 1)) ? '0
                                                                       : rd_idx_q + 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_idx_q <= '0;
            rdptr_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_idx_q <= rd_idx_d;
            rdptr_q  <= rdptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign readpointer_o = rdptr_q;
    assign data_o        = data_q;
    assign valid_o       = valid_q;

endmodule

// File: tb/tb_token_ring_fifo_reader.sv
`timescale 1ns/1ps

module tb_token_ring_fifo_reader;
    import token_fifo_pkg::*;

    localparam int DW     = 32;
    localparam int BW     = 8;
    localparam int SYNC_N = TOKEN_SYNC_STAGES;

    logic             clk = 1'b0;
    logic             rstn_i;
    logic [BW-1:0]    writetoken;
    logic [BW*DW-1:0] data_async;
    logic [BW-1:0]    rp;
    logic [DW-1:0]    data_o;
    logic             valid_o;
    logic             ready;

    token_ring_fifo_reader #(
        .DATA_WIDTH   (DW),
        .BUFFER_WIDTH (BW)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .writetoken_i  (writetoken),
        .data_async_i  (data_async),
        .readpointer_o (rp),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];   // words the writer has published, in order
    int            wr_idx;
    bit            wr_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Writer model: wait for its next ring slot to be free, publish data,
    // then toggle the token one cycle later.
    task automatic write_word(input logic [DW-1:0] w);
        int t = 0;
        while (writetoken[wr_idx] !== rp[wr_idx] && t < 200) begin
            step();
            t++;
        end
        chk("wr_slot_free", {63'd0, writetoken[wr_idx] === rp[wr_idx]}, 64'd1);
        data_async[wr_idx*DW +: DW] = w;
        step();
        writetoken[wr_idx] = ~writetoken[wr_idx];
        exp_q.push_back(w);
        wr_idx = (wr_idx + 1) % BW;
    endtask

    task automatic clear_writer();
        writetoken = '0;
        data_async = '0;
        wr_idx     = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        clear_writer();
        step();
        rstn_i = 1'b1;
    endtask

    // Monitor: in-order delivery, stall stability, one release per cycle.
    logic          pv, pr;
    logic [DW-1:0] pd;
    logic [BW-1:0] prp;
    logic [DW-1:0] mon_exp;
    bit            have_prev = 1'b0;

    always @(negedge clk) begin
        if (!rstn_i) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                if (pv && !pr) begin
                    chk("hold_valid", {63'd0, valid_o}, 64'd1);
                    chk("hold_data", {32'd0, data_o}, {32'd0, pd});
                end
                chk("rp_one_bit", {63'd0, ($countones(rp ^ prp) <= 1)}, 64'd1);
            end
            if (valid_o && ready) begin
                chk("queue_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("order", {32'd0, data_o}, {32'd0, mon_exp});
                end
                $display("accept data=0x%08h rp=0x%02h", data_o, rp);
            end
            pv        = valid_o;
            pr        = ready;
            pd        = data_o;
            prp       = rp;
            have_prev = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] exp_rp;
        int            budget;

        rstn_i = 1'b0;
        ready  = 1'b0;
        clear_writer();
        #1;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data", {32'd0, data_o}, 64'd0);
        chk("rst_rp", {56'd0, rp}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rstn_i = 1'b1;

        // Single word: valid exactly SYNC_N+1 edges after the token toggle.
        ready = 1'b1;
        write_word(32'hDEADBEEF);
        repeat (SYNC_N) step();
        chk("lat_early", {63'd0, valid_o}, 64'd0);
        step();
        chk("lat_valid", {63'd0, valid_o}, 64'd1);
        chk("lat_data", {32'd0, data_o}, 64'hDEADBEEF);
        chk("lat_rp", {56'd0, rp}, 64'h01);
        step();
        chk("single_drop", {63'd0, valid_o}, 64'd0);

        // Full ring under backpressure, then back-to-back drain.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < BW; i++) write_word(DW'(i));
        repeat (SYNC_N + 2) step();
        chk("ring_valid", {63'd0, valid_o}, 64'd1);
        chk("ring_data0", {32'd0, data_o}, 64'd0);
        chk("ring_rp0", {56'd0, rp}, 64'h01);
        ready = 1'b1;
        for (int i = 1; i < BW; i++) begin
            step();
            exp_rp = BW'((1 << (i + 1)) - 1);
            chk("ring_valid_b2b", {63'd0, valid_o}, 64'd1);
            chk("ring_data", {32'd0, data_o}, 64'(i));
            chk("ring_rp", {56'd0, rp}, {56'd0, exp_rp});
        end
        step();
        chk("ring_empty", {63'd0, valid_o}, 64'd0);
        chk("ring_rp_all", {56'd0, rp}, 64'hFF);

        // Random writer pacing and random backpressure, 20 words (wraps twice).
        do_reset();
        wr_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    write_word(DW'(i));
                end
                wr_done = 1'b1;
            end
            begin
                budget = 0;
                while (!wr_done && budget < 5000) begin
                    step();
                    ready = 1'($urandom_range(0, 1));
                    budget++;
                end
            end
        join
        ready  = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || valid_o) && budget < 200) begin
            step();
            budget++;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_valid_low", {63'd0, valid_o}, 64'd0);
        exp_rp = '0;
        for (int i = 0; i < 20; i++) exp_rp[i % BW] = ~exp_rp[i % BW];
        chk("rand_rp", {56'd0, rp}, {56'd0, exp_rp});

        // Reset in the middle of a stream with words pending.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(32'hA0 + DW'(i));
        repeat (SYNC_N + 2) step();
        chk("mid_pending", {63'd0, valid_o}, 64'd1);
        #1;
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("mid_rst_data", {32'd0, data_o}, 64'd0);
        chk("mid_rst_rp", {56'd0, rp}, 64'd0);
        clear_writer();
        step();
        rstn_i = 1'b1;
        ready  = 1'b1;
        write_word(32'hCAFEF00D);
        repeat (SYNC_N + 1) step();
        chk("post_rst_valid", {63'd0, valid_o}, 64'd1);
        chk("post_rst_data", {32'd0, data_o}, 64'hCAFEF00D);
        chk("post_rst_rp", {56'd0, rp}, 64'h01);
        step();
        chk("post_rst_drop", {63'd0, valid_o}, 64'd0);

        chk("leftover", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
